// File: rtl/spi_burst_sequencer.sv
// spi_burst_sequencer: byte-stream front end for the SPI master.
// TX bytes are buffered, then played one at a time into the master's
// work-enable/data inputs after a start pulse. Each byte completes once both
// send-finish and receive-finish have been seen. The received byte is then
// written into the RX FIFO.
//
// state | meaning
// IDLE  | waiting for start with a non-empty TX FIFO
// LOAD  | pop TX head into spi_data, one cycle
// XFER  | spi_work_en high, collecting send/receive finish pulses
// GAP   | spi_work_en low for GAP_CYCLES cycles between bytes
// DONE  | one-cycle done pulse, then back to IDLE

module spi_burst_sequencer #(
    parameter int FIFO_DEPTH = 16,
    parameter int FIFO_AW    = 4,
    parameter int GAP_CYCLES = 4,
    parameter int GAP_W      = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tx_wr_en,
    input  logic [7:0]         tx_wr_data,
    output logic               tx_full,
    output logic [FIFO_AW:0]   tx_level,
    input  logic               start,
    output logic               busy,
    output logic               done,
    input  logic               rx_rd_en,
    output logic [7:0]         rx_rd_data,
    output logic               rx_empty,
    output logic [FIFO_AW:0]   rx_level,
    output logic               rx_overflow,
    output logic               spi_work_en,
    output logic [7:0]         spi_data,
    input  logic [7:0]         spi_rx_data,
    input  logic               spi_send_finish,
    input  logic               spi_receive_finish
);

    typedef enum logic [2:0] {IDLE, LOAD, XFER, GAP, DONE} state_t;

    localparam logic [FIFO_AW:0] DEPTH_L  = (FIFO_AW+1)'(FIFO_DEPTH);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    state_t               state;
    logic [FIFO_AW:0]     remaining;
    logic [GAP_W-1:0]     gap_cnt;
    logic                 send_seen;
    logic                 recv_seen;
    logic [7:0]           rx_capture;

    logic [7:0]           tx_mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0]   tx_wr_ptr;
    logic [FIFO_AW-1:0]   tx_rd_ptr;
    logic [FIFO_AW:0]     tx_cnt;
    logic                 tx_push;
    logic                 tx_pop;

    logic [7:0]           rx_mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0]   rx_wr_ptr;
    logic [FIFO_AW-1:0]   rx_rd_ptr;
    logic [FIFO_AW:0]     rx_cnt;
    logic                 rx_full;
    logic                 rx_push;
    logic                 rx_pop;

    logic                 send_now;
    logic                 recv_now;
    logic                 byte_done;
    logic [7:0]           rx_wr_byte;

    // Completion sees this cycle's pulses so a same-cycle pair finishes at once;
    // a byte arriving with the final pulse bypasses the capture register.
    always_comb begin
        send_now   = send_seen | spi_send_finish;
        recv_now   = recv_seen | spi_receive_finish;
        byte_done  = (state == XFER) && send_now && recv_now;
        rx_wr_byte = spi_receive_finish ? spi_rx_data : rx_capture;
    end

    // FIFO handshakes, status flags and first-word-fall-through read port
    always_comb begin
        tx_full    = (tx_cnt == DEPTH_L);
        tx_level   = tx_cnt;
        tx_push    = tx_wr_en && !tx_full;
        tx_pop     = (state == LOAD) && (tx_cnt != '0);
        rx_full    = (rx_cnt == DEPTH_L);
        rx_empty   = (rx_cnt == '0);
        rx_level   = rx_cnt;
        rx_push    = byte_done && !rx_full;
        rx_pop     = rx_rd_en && !rx_empty;
        rx_rd_data = rx_empty ? 8'h00 : rx_mem[rx_rd_ptr];
    end

    // TX storage write
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wr_ptr] <= tx_wr_data;
    end

    // TX pointers and occupancy; push and pop in one cycle cancel
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_cnt    <= '0;
        end else begin
            if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
            if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + 1'b1;
            case ({tx_push, tx_pop})
                2'b10:   tx_cnt <= tx_cnt + 1'b1;
                2'b01:   tx_cnt <= tx_cnt - 1'b1;
                default: tx_cnt <= tx_cnt;
            endcase
        end
    end

    // RX storage write
    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wr_ptr] <= rx_wr_byte;
    end

    // RX pointers and occupancy; write and pop in one cycle cancel
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            rx_cnt    <= '0;
        end else begin
            if (rx_push) rx_wr_ptr <= rx_wr_ptr + 1'b1;
            if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + 1'b1;
            case ({rx_push, rx_pop})
                2'b10:   rx_cnt <= rx_cnt + 1'b1;
                2'b01:   rx_cnt <= rx_cnt - 1'b1;
                default: rx_cnt <= rx_cnt;
            endcase
        end
    end

    // Burst sequencer with registered handshake outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            remaining   <= '0;
            gap_cnt     <= '0;
            send_seen   <= 1'b0;
            recv_seen   <= 1'b0;
            rx_capture  <= 8'h00;
            spi_work_en <= 1'b0;
            spi_data    <= 8'h00;
            busy        <= 1'b0;
            done        <= 1'b0;
            rx_overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            if (byte_done && rx_full) rx_overflow <= 1'b1;
            case (state)
                IDLE: begin
                    // Byte count is frozen here so later pushes wait for the next burst
                    if (start && (tx_cnt != '0)) begin
                        remaining   <= tx_cnt;
                        rx_overflow <= 1'b0;
                        busy        <= 1'b1;
                        state       <= LOAD;
                    end
                end
                LOAD: begin
                    spi_data    <= tx_mem[tx_rd_ptr];
                    remaining   <= remaining - 1'b1;
                    spi_work_en <= 1'b1;
                    state       <= XFER;
                end
                XFER: begin
                    if (spi_receive_finish) rx_capture <= spi_rx_data;
                    if (byte_done) begin
                        send_seen   <= 1'b0;
                        recv_seen   <= 1'b0;
                        spi_work_en <= 1'b0;
                        gap_cnt     <= GAP_LAST;
                        state       <= GAP;
                    end else begin
                        send_seen <= send_now;
                        recv_seen <= recv_now;
                    end
                end
                GAP: begin
                    if (gap_cnt == '0) begin
                        if (remaining != '0) begin
                            state <= LOAD;
                        end else begin
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_burst_sequencer.sv
// Directed bench for spi_burst_sequencer. A queue holds the TX bytes expected
// on spi_data, and a second queue holds the RX bytes the master model returns.
// Both queues are popped as the DUT presents or delivers bytes.

module tb_spi_burst_sequencer;

    localparam int GAP = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       tx_wr_en;
    logic [7:0] tx_wr_data;
    logic       tx_full;
    logic [4:0] tx_level;
    logic       start;
    logic       busy;
    logic       done;
    logic       rx_rd_en;
    logic [7:0] rx_rd_data;
    logic       rx_empty;
    logic [4:0] rx_level;
    logic       rx_overflow;
    logic       spi_work_en;
    logic [7:0] spi_data;
    logic [7:0] spi_rx_data;
    logic       spi_send_finish;
    logic       spi_receive_finish;

    int checks   = 0;
    int errors   = 0;
    int done_cnt = 0;
    int exp_done = 0;

    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];

    spi_burst_sequencer dut (
        .clk                (clk),
        .rst                (rst),
        .tx_wr_en           (tx_wr_en),
        .tx_wr_data         (tx_wr_data),
        .tx_full            (tx_full),
        .tx_level           (tx_level),
        .start              (start),
        .busy               (busy),
        .done               (done),
        .rx_rd_en           (rx_rd_en),
        .rx_rd_data         (rx_rd_data),
        .rx_empty           (rx_empty),
        .rx_level           (rx_level),
        .rx_overflow        (rx_overflow),
        .spi_work_en        (spi_work_en),
        .spi_data           (spi_data),
        .spi_rx_data        (spi_rx_data),
        .spi_send_finish    (spi_send_finish),
        .spi_receive_finish (spi_receive_finish)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (done === 1'b1) done_cnt <= done_cnt + 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_tx(input logic [7:0] b, input bit record);
        tx_wr_en   = 1'b1;
        tx_wr_data = b;
        tick();
        tx_wr_en   = 1'b0;
        if (record) tx_q.push_back(b);
    endtask

    task automatic begin_burst();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_in_load", busy, 1);
        check("we_in_load", spi_work_en, 0);
    endtask

    task automatic wait_we(output int lows);
        lows = 0;
        while (spi_work_en !== 1'b1 && lows < 50) begin
            lows++;
            tick();
        end
        check("we_rise", spi_work_en, 1);
    endtask

    // Master model: finish pulses at given offsets into the XFER window.
    task automatic serve(input int sdly, input int rdly, input logic [7:0] rxb,
                         input int delta, input bit drop, input bit rd_last);
        int last;
        int lvl0;
        logic [7:0] txb;
        last = (sdly > rdly) ? sdly : rdly;
        lvl0 = int'(rx_level);
        txb  = tx_q.pop_front();
        for (int c = 0; c <= last; c++) begin
            check("xfer_we_high", spi_work_en, 1);
            check("spi_data", spi_data, txb);
            spi_send_finish    = (c == sdly);
            spi_receive_finish = (c == rdly);
            spi_rx_data        = (c == rdly) ? rxb : ~rxb;
            if (c == rdly && !drop) rx_q.push_back(rxb);
            if (c == last && rd_last) begin
                check("rd_same_cycle_head", rx_rd_data, rx_q.pop_front());
                rx_rd_en = 1'b1;
            end
            tick();
        end
        spi_send_finish    = 1'b0;
        spi_receive_finish = 1'b0;
        rx_rd_en           = 1'b0;
        spi_rx_data        = ~rxb;
        check("we_low_after_byte", spi_work_en, 0);
        check("rx_level_step", rx_level, lvl0 + delta);
    endtask

    task automatic byte_xfer(input int lows_exp, input int sdly, input int rdly,
                             input logic [7:0] rxb, input int delta,
                             input bit drop, input bit rd_last);
        int lows;
        wait_we(lows);
        check("we_low_cycles", lows, lows_exp);
        serve(sdly, rdly, rxb, delta, drop, rd_last);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (done !== 1'b1 && n < 50) begin
            n++;
            tick();
        end
        check("done_pulse", done, 1);
        check("done_latency", n, GAP);
        check("busy_in_done", busy, 1);
        exp_done++;
        tick();
        check("done_one_cycle", done, 0);
        check("busy_after_done", busy, 0);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin
            check("rx_not_empty", rx_empty, 0);
            check("rx_rd_data", rx_rd_data, rx_q.pop_front());
            rx_rd_en = 1'b1;
            tick();
            rx_rd_en = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1; tx_wr_en = 1'b0; tx_wr_data = 8'h00; start = 1'b0;
        rx_rd_en = 1'b0; spi_rx_data = 8'h00;
        spi_send_finish = 1'b0; spi_receive_finish = 1'b0;
        repeat (3) tick();

        // Reset values
        check("rst_we", spi_work_en, 0);
        check("rst_spi_data", spi_data, 8'h00);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_overflow", rx_overflow, 0);
        check("rst_tx_level", tx_level, 0);
        check("rst_rx_level", rx_level, 0);
        check("rst_tx_full", tx_full, 0);
        check("rst_rx_empty", rx_empty, 1);
        check("rst_rx_rd_data", rx_rd_data, 8'h00);
        rst = 1'b0;
        tick();

        // Three-byte burst, master returns 0x62 for every byte
        push_tx(8'h61, 1); push_tx(8'h62, 1); push_tx(8'h63, 1);
        check("tx_level_3", tx_level, 3);
        begin_burst();
        byte_xfer(1,   2, 3, 8'h62, 1, 0, 0);
        byte_xfer(GAP + 1, 1, 1, 8'h62, 1, 0, 0);
        byte_xfer(GAP + 1, 3, 2, 8'h62, 1, 0, 0);
        wait_done();
        check("done_count_b1", done_cnt, exp_done);
        check("tx_level_b1", tx_level, 0);
        check("rx_level_b1", rx_level, 3);
        drain(3);
        check("rx_empty_b1", rx_empty, 1);

        // Finish orderings: send first, same cycle, receive first
        push_tx(8'hA1, 1); push_tx(8'hA2, 1); push_tx(8'hA3, 1);
        begin_burst();
        byte_xfer(1,   0, 5, 8'h11, 1, 0, 0);
        byte_xfer(GAP + 1, 0, 0, 8'h22, 1, 0, 0);
        byte_xfer(GAP + 1, 3, 0, 8'h33, 1, 0, 0);
        wait_done();
        drain(3);

        // Push during LOAD pop, RX read during RX write
        push_tx(8'hB1, 1); push_tx(8'hB2, 1);
        begin_burst();
        check("tx_level_pre_load", tx_level, 2);
        tx_wr_en   = 1'b1;
        tx_wr_data = 8'h77;
        tx_q.push_back(8'h77);
        tick();
        tx_wr_en = 1'b0;
        check("tx_level_push_pop", tx_level, 2);
        byte_xfer(0,   1, 1, 8'h44, 1, 0, 0);
        byte_xfer(GAP + 1, 2, 1, 8'h55, 0, 0, 1);
        wait_done();
        check("tx_level_leftover", tx_level, 1);
        drain(1);

        // Fill RX with 16 bytes, then overflow with a 2-byte burst
        for (int k = 0; k < 15; k++) push_tx(8'(8'h80 + k), 1);
        check("tx_full", tx_full, 1);
        check("tx_level_16", tx_level, 16);
        push_tx(8'hEE, 0);
        check("tx_push_when_full", tx_level, 16);
        begin_burst();
        for (int k = 0; k < 16; k++)
            byte_xfer((k == 0) ? 1 : GAP + 1, 1, 1, 8'(8'hC0 + k), 1, 0, 0);
        wait_done();
        check("rx_level_full", rx_level, 16);
        check("no_overflow_yet", rx_overflow, 0);
        push_tx(8'hD0, 1); push_tx(8'hD1, 1);
        begin_burst();
        byte_xfer(1,   1, 1, 8'hE1, 0, 1, 0);
        byte_xfer(GAP + 1, 0, 2, 8'hE2, 0, 1, 0);
        wait_done();
        check("done_count_ovf", done_cnt, exp_done);
        check("rx_overflow_set", rx_overflow, 1);
        check("rx_level_ovf", rx_level, 16);
        drain(16);
        check("overflow_sticky", rx_overflow, 1);
        push_tx(8'h5A, 1);
        begin_burst();
        check("overflow_cleared", rx_overflow, 0);
        byte_xfer(1, 1, 0, 8'h3C, 1, 0, 0);
        wait_done();
        drain(1);

        // Start with an empty TX FIFO is ignored
        check("tx_level_empty", tx_level, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("empty_start_busy", busy, 0);
            check("empty_start_we", spi_work_en, 0);
            tick();
        end
        check("done_count_empty", done_cnt, exp_done);

        // Reset during byte 2 of 4
        push_tx(8'h91, 1); push_tx(8'h92, 1); push_tx(8'h93, 1); push_tx(8'h94, 1);
        begin_burst();
        byte_xfer(1, 1, 2, 8'hA1, 1, 0, 0);
        begin
            int lows;
            wait_we(lows);
            check("we_low_cycles_rst", lows, GAP + 1);
        end
        check("spi_data_byte2", spi_data, tx_q.pop_front());
        rst = 1'b1;
        tick();
        check("rst_mid_we", spi_work_en, 0);
        check("rst_mid_tx_level", tx_level, 0);
        check("rst_mid_rx_level", rx_level, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_rx_empty", rx_empty, 1);
        rst = 1'b0;
        tx_q.delete();
        rx_q.delete();
        repeat (6) tick();
        check("rst_mid_no_done", done_cnt, exp_done);
        check("rst_mid_idle_busy", busy, 0);

        // Pop on empty RX is ignored
        rx_rd_en = 1'b1;
        tick();
        rx_rd_en = 1'b0;
        check("rd_empty_level", rx_level, 0);
        check("rd_empty_flag", rx_empty, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_burst_sequencer.md
# spi_burst_sequencer

Byte-stream front end for the SPI master. It buffers transmit bytes in a TX FIFO and, on a start pulse, feeds them one at a time to the master's work-enable/data inputs. For each byte it waits for both send-finish and receive-finish, then captures the master's received byte into an RX FIFO. It sits directly upstream of the SPI master and replaces the one-shot work-enable logic used in bring-up.

## Interface
- FIFO_DEPTH, 16, entries in each of the TX and RX FIFOs (power of two, ≥2)
- FIFO_AW, 4, log2(FIFO_DEPTH)
- GAP_CYCLES, 4, idle cycles with spi_work_en low between bytes (≥1)
- GAP_W, 3, width of gap counter (must hold GAP_CYCLES)
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- tx_wr_en  in  1  push tx_wr_data into TX FIFO
- tx_wr_data  in  8  byte to transmit
- tx_full  out  1  TX FIFO full
- tx_level  out  FIFO_AW+1  TX FIFO occupancy
- start  in  1  begin burst (single-cycle pulse)
- busy  out  1  burst in progress
- done  out  1  one-cycle pulse at burst completion
- rx_rd_en  in  1  pop RX FIFO head
- rx_rd_data  out  8  RX FIFO head, first-word-fall-through
- rx_empty  out  1  RX FIFO empty
- rx_level  out  FIFO_AW+1  RX FIFO occupancy
- rx_overflow  out  1  sticky: a received byte was dropped
- spi_work_en  out  1  to master im_work_en
- spi_data  out  8  to master im_data
- spi_rx_data  in  8  from master om_data, valid when spi_receive_finish=1
- spi_send_finish  in  1  master send-finish pulse
- spi_receive_finish  in  1  master receive-finish pulse

## Operation
- States: IDLE, LOAD, XFER, GAP, DONE.
- IDLE: when start=1 and tx_level≠0, latch remaining=tx_level and clear rx_overflow → LOAD. Ignore start when tx_level=0, or when start arrives outside IDLE.
- LOAD: pop TX head into the spi_data register; decrement remaining → XFER.
- XFER: spi_work_en=1. Set flags send_seen and recv_seen independently from the finish pulses; the two pulses may arrive in the same cycle or in either order. On a receive_finish pulse, hold spi_rx_data in a capture register. When both flags are set (counting the current cycle's pulses), clear the flags, write the captured byte to the RX FIFO, and → GAP.
- GAP: spi_work_en=0 for exactly GAP_CYCLES cycles, then → LOAD if remaining≠0, else → DONE.
- DONE: done=1 for one cycle → IDLE.
- busy=1 in LOAD, XFER, GAP and DONE; busy=0 in IDLE.
- spi_data is stable for the whole time spi_work_en=1.
- Finish pulses outside XFER are ignored.
- TX FIFO:
  - A push when full is ignored; its contents are unchanged.
  - Pushes during a burst are allowed but do not extend it, because remaining was snapshotted at start.
  - A push and a LOAD pop in the same cycle both take effect; tx_level is unchanged.
- RX FIFO:
  - A write when full drops the byte and sets rx_overflow. rx_overflow stays set until rst or the next accepted start.
  - rx_rd_en when empty is ignored.
  - A write and a pop in the same cycle both take effect.
- Pointers are FIFO_AW bits and wrap modulo FIFO_DEPTH; levels are FIFO_AW+1 bits.

## Timing
- Reset values: spi_work_en=0, spi_data=0x00, busy=0, done=0, rx_overflow=0, tx_level=0, rx_level=0, tx_full=0, rx_empty=1, rx_rd_data=0x00, state=IDLE, flags cleared.
- Reset mid-burst: spi_work_en drops after the edge where rst=1, both FIFOs are emptied, and no done pulse is issued.
- Burst start: start sampled at edge N; LOAD during cycle N+1; spi_work_en=1 and the new spi_data are visible from edge N+2.
- Byte completion: last finish pulse sampled at edge M; from edge M+1, spi_work_en=0 and rx_level has incremented.
- Next byte: spi_work_en rises again at edge M+1+GAP_CYCLES+1, one cycle of that being LOAD.
- Burst end: after the last byte's gap, done=1 for one cycle. busy falls on the edge that ends DONE.
- rx_rd_data reflects the new head on the cycle after a pop, or after a write into an empty FIFO.

## Test plan
- Burst of three bytes: push 0x61, 0x62, 0x63; pulse start; master model returns 0x62 for every byte. Required: three spi_work_en windows presenting 0x61, 0x62, 0x63 in order; each low gap is ≥GAP_CYCLES+1 cycles; rx_level=3, reading 0x62 three times; a single done pulse; busy low afterwards.
- Finish ordering:
  - send_finish 5 cycles before receive_finish: byte completes one cycle after receive_finish.
  - Both pulses in the same cycle: byte completes the next cycle.
  - receive_finish first: byte completes after send_finish. The captured byte equals spi_rx_data at the receive pulse, not later values.
- RX overflow: preload the RX FIFO with 16 bytes and run a 2-byte burst. Required: rx_overflow=1, rx_level=16, the original 16 bytes intact, done still pulses. The next start clears rx_overflow.
- Empty start: start with tx_level=0. Required: busy stays 0, spi_work_en stays 0, no done.
- Concurrent FIFO traffic: push a byte in the same cycle as a LOAD pop, and read RX in the same cycle as an RX write. Required: both levels are unchanged in those cycles, and the extra TX byte remains after done (tx_level=1).
- Reset mid-burst: assert rst while spi_work_en=1 during byte 2 of 4. Required: next cycle spi_work_en=0, tx_level=0, rx_level=0, busy=0, and no done pulse.
